// File: rtl/id_ex_if.sv
// ID -> EX handshake bundle: decoded fields in, registered EX copies and
// interlock status out.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic [1:0]        id_alu_op;
    logic [5:0]        id_ctrl;
    logic              ex_flush;
    logic              hold;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;
    logic [1:0]        ex_alu_op;
    logic [5:0]        ex_ctrl;
    logic              load_use_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    // ID side / pipeline control
    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_alu_op, id_ctrl,
               ex_flush, hold,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_alu_op, ex_ctrl,
               load_use_stall, bubble_cnt
    );

    // the stage register itself
    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_alu_op, id_ctrl,
               ex_flush, hold,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_alu_op, ex_ctrl,
               load_use_stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use interlock, flush squash, downstream
// hold and a saturating count of interlock bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic  clk,
    input  logic  reset,   // async, active low
    id_ex_if.slave bus
);
    // id_ctrl = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
    localparam int CTRL_MEM_READ = 4;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [1:0]        alu_op;
        logic [5:0]        ctrl;
    } stage_t;

    stage_t           id_s, ex_d, ex_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             stall;

    // gather the ID-side fields into one record
    always_comb begin
        id_s          = '0;
        id_s.valid    = bus.id_valid;
        id_s.pc       = bus.id_pc;
        id_s.rs1_data = bus.id_rs1_data;
        id_s.rs2_data = bus.id_rs2_data;
        id_s.imm      = bus.id_imm;
        id_s.rs1      = bus.id_rs1;
        id_s.rs2      = bus.id_rs2;
        id_s.rd       = bus.id_rd;
        id_s.funct3   = bus.id_funct3;
        id_s.funct7   = bus.id_funct7;
        id_s.alu_op   = bus.id_alu_op;
        id_s.ctrl     = bus.id_ctrl;
    end

    // Load in EX whose destination feeds ID: stall. x0 is never a hazard;
    // flush/hold suppress it because they already decide this edge.
    assign stall = ex_q.valid & ex_q.ctrl[CTRL_MEM_READ] & bus.id_valid
                 & (ex_q.rd != '0)
                 & ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2))
                 & ~bus.ex_flush & ~bus.hold;

    // next state: flush > hold > interlock bubble > normal load
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (bus.ex_flush) begin
            ex_d        = id_s;
            ex_d.valid  = 1'b0;
            ex_d.ctrl   = '0;
            ex_d.alu_op = '0;
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (stall) begin
            ex_d        = id_s;
            ex_d.valid  = 1'b0;
            ex_d.ctrl   = '0;
            ex_d.alu_op = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
            ex_d = id_s;
            if (!bus.id_valid) ex_d.ctrl = '0;
        end
    end

    // stage register and bubble counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_rs1_data    = ex_q.rs1_data;
    assign bus.ex_rs2_data    = ex_q.rs2_data;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_rs1         = ex_q.rs1;
    assign bus.ex_rs2         = ex_q.rs2;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_funct3      = ex_q.funct3;
    assign bus.ex_funct7      = ex_q.funct7;
    assign bus.ex_alu_op      = ex_q.alu_op;
    assign bus.ex_ctrl        = ex_q.ctrl;
    assign bus.load_use_stall = stall;
    assign bus.bubble_cnt     = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus random stream against
// a rule-level model; a second instance with a 2-bit counter shares stimulus.
module tb_id_ex_stage_reg;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
    id_ex_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  bus2 ();

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.id_valid    = bus.id_valid;
    assign bus2.id_pc       = bus.id_pc;
    assign bus2.id_rs1_data = bus.id_rs1_data;
    assign bus2.id_rs2_data = bus.id_rs2_data;
    assign bus2.id_imm      = bus.id_imm;
    assign bus2.id_rs1      = bus.id_rs1;
    assign bus2.id_rs2      = bus.id_rs2;
    assign bus2.id_rd       = bus.id_rd;
    assign bus2.id_funct3   = bus.id_funct3;
    assign bus2.id_funct7   = bus.id_funct7;
    assign bus2.id_alu_op   = bus.id_alu_op;
    assign bus2.id_ctrl     = bus.id_ctrl;
    assign bus2.ex_flush    = bus.ex_flush;
    assign bus2.hold        = bus.hold;

    int checks = 0;
    int failures = 0;

    // reference: what EX should hold, by the stated rules
    logic        m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [1:0]  m_aop;
    logic [5:0]  m_ctrl;
    int          m_cnt, m_cnt2;

    localparam logic [5:0] C_LW  = 6'b110110;
    localparam logic [5:0] C_ALU = 6'b000100;

    function automatic void model_reset();
        m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_aop = 0; m_ctrl = 0;
        m_cnt = 0; m_cnt2 = 0;
    endfunction

    function automatic logic model_stall();
        return m_valid && m_ctrl[4] && bus.id_valid && (m_rd != 0) &&
               (m_rd == bus.id_rs1 || m_rd == bus.id_rs2) && !bus.ex_flush && !bus.hold;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [5:0] ctrl, input logic [1:0] aop,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic fl, input logic hd);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_ctrl = ctrl; bus.id_alu_op = aop; bus.id_funct3 = f3; bus.id_funct7 = f7;
        bus.id_pc = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
        bus.id_imm = $urandom; bus.ex_flush = fl; bus.hold = hd;
    endtask

    // one clock: check the interlock, advance the model, check EX outputs
    task automatic step();
        logic es;
        #1;
        es = model_stall();
        checks++;
        if (bus.load_use_stall !== es) begin
            failures++; $display("FAIL stall got=%0b exp=%0b t=%0t", bus.load_use_stall, es, $time);
        end
        @(posedge clk);
        if (bus.ex_flush) begin
            m_valid = 0; m_ctrl = 0; m_aop = 0;
        end else if (bus.hold) begin
            m_valid = m_valid;
        end else if (es) begin
            m_valid = 0; m_ctrl = 0; m_aop = 0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            m_valid = bus.id_valid; m_ctrl = bus.id_valid ? bus.id_ctrl : 6'd0;
            m_aop = bus.id_alu_op; m_pc = bus.id_pc; m_d1 = bus.id_rs1_data;
            m_d2 = bus.id_rs2_data; m_imm = bus.id_imm; m_rs1 = bus.id_rs1;
            m_rs2 = bus.id_rs2; m_rd = bus.id_rd; m_f3 = bus.id_funct3; m_f7 = bus.id_funct7;
        end
        #1;
        checks++;
        if (bus.ex_valid !== m_valid || bus.ex_ctrl !== m_ctrl || bus.ex_alu_op !== m_aop) begin
            failures++;
            $display("FAIL ex_ctl got v=%0b c=%b a=%b exp v=%0b c=%b a=%b t=%0t",
                     bus.ex_valid, bus.ex_ctrl, bus.ex_alu_op, m_valid, m_ctrl, m_aop, $time);
        end
        checks++;
        if (bus.bubble_cnt !== 16'(m_cnt) || bus2.bubble_cnt !== 2'(m_cnt2)) begin
            failures++;
            $display("FAIL bubble_cnt got=%0d/%0d exp=%0d/%0d t=%0t",
                     bus.bubble_cnt, bus2.bubble_cnt, m_cnt, m_cnt2, $time);
        end
        if (m_valid) begin
            checks++;
            if ({bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_rs1, bus.ex_rs2,
                 bus.ex_rd, bus.ex_funct3, bus.ex_funct7} !==
                {m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7}) begin
                failures++;
                $display("FAIL ex_data got pc=%h rd=%0d f7=%b exp pc=%h rd=%0d f7=%b t=%0t",
                         bus.ex_pc, bus.ex_rd, bus.ex_funct7, m_pc, m_rd, m_f7, $time);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ex_valid !== 0 || bus.ex_ctrl !== 0 || bus.ex_pc !== 0 || bus.ex_rd !== 0 ||
            bus.bubble_cnt !== 0 || bus.load_use_stall !== 0) begin
            failures++; $display("FAIL reset_state got v=%0b c=%b pc=%h cnt=%0d",
                                 bus.ex_valid, bus.ex_ctrl, bus.ex_pc, bus.bubble_cnt);
        end
        #4 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        drive(1, 1, 2, 5, C_LW, 2'b00, 3'b010, 7'd0, 0, 0);     // LW x5
        step();
        drive(1, 5, 1, 6, C_ALU, 2'b10, 3'b000, 7'd0, 0, 0);    // ADD x6,x5,x1
        #1;
        checks++;
        if (bus.load_use_stall !== 1'b1) begin
            failures++; $display("FAIL lu_stall got=%0b exp=1", bus.load_use_stall);
        end
        step();
        checks++;
        if (bus.ex_valid !== 0 || bus.ex_ctrl !== 0 || bus.bubble_cnt !== 16'd1) begin
            failures++; $display("FAIL lu_bubble got v=%0b c=%b cnt=%0d exp 0/0/1",
                                 bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt);
        end
        step();
        checks++;
        if (bus.ex_valid !== 1 || bus.ex_alu_op !== 2'b10 || bus.ex_funct7 !== 7'd0 || bus.ex_rd !== 5'd6) begin
            failures++; $display("FAIL lu_release got v=%0b a=%b f7=%b rd=%0d exp 1/10/0/6",
                                 bus.ex_valid, bus.ex_alu_op, bus.ex_funct7, bus.ex_rd);
        end
    endtask

    task automatic test_x0();
        drive(1, 1, 2, 0, C_LW, 2'b00, 3'b010, 7'd0, 0, 0);     // LW x0
        step();
        drive(1, 0, 0, 7, C_ALU, 2'b10, 3'b000, 7'd0, 0, 0);
        step();
        checks++;
        if (bus.ex_valid !== 1 || bus.ex_rd !== 5'd7) begin
            failures++; $display("FAIL x0_nostall got v=%0b rd=%0d exp 1/7", bus.ex_valid, bus.ex_rd);
        end
    endtask

    task automatic test_flush_hazard();
        int c0;
        drive(1, 1, 2, 5, C_LW, 2'b00, 3'b010, 7'd0, 0, 0);
        step();
        c0 = m_cnt;
        drive(1, 3, 5, 6, C_ALU, 2'b10, 3'b000, 7'd0, 1, 1);    // flush beats hold and hazard
        step();
        checks++;
        if (bus.ex_valid !== 0 || bus.ex_ctrl !== 0 || bus.bubble_cnt !== 16'(c0)) begin
            failures++; $display("FAIL flush got v=%0b c=%b cnt=%0d exp 0/0/%0d",
                                 bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, c0);
        end
    endtask

    task automatic test_hold();
        logic [31:0] pc0;
        drive(1, 1, 2, 9, C_ALU, 2'b10, 3'b000, 7'b0100000, 0, 0);   // SUB
        step();
        pc0 = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 4, 10, C_LW, 2'b00, 3'b010, 7'd0, 0, 1);
            step();
        end
        checks++;
        if (bus.ex_pc !== pc0 || bus.ex_funct7 !== 7'b0100000 || bus.ex_valid !== 1) begin
            failures++; $display("FAIL hold got pc=%h f7=%b exp pc=%h f7=0100000",
                                 bus.ex_pc, bus.ex_funct7, pc0);
        end
        drive(1, 3, 4, 11, C_ALU, 2'b10, 3'b001, 7'd0, 0, 0);
        pc0 = bus.id_pc;
        step();
        checks++;
        if (bus.ex_pc !== pc0 || bus.ex_rd !== 5'd11) begin
            failures++; $display("FAIL hold_release got pc=%h rd=%0d exp pc=%h rd=11",
                                 bus.ex_pc, bus.ex_rd, pc0);
        end
    endtask

    task automatic test_saturate();
        int c0;
        c0 = m_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 2, 5, C_LW, 2'b00, 3'b010, 7'd0, 0, 0);
            step();
            drive(1, 1, 5, 6, C_ALU, 2'b10, 3'b000, 7'd0, 0, 0);
            step();
        end
        checks++;
        if (bus2.bubble_cnt !== 2'd3 || bus.bubble_cnt !== 16'(c0 + 5)) begin
            failures++; $display("FAIL saturate got=%0d/%0d exp=3/%0d",
                                 bus2.bubble_cnt, bus.bubble_cnt, c0 + 5);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? C_LW : 6'($urandom),
                  2'($urandom), 3'($urandom), 7'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            step();
        end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 2, 12, C_LW, 2'b00, 3'b010, 7'd0, 0, 0);
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 0 || bus.ex_ctrl !== 0 || bus.ex_pc !== 0 || bus.ex_rd !== 0 ||
            bus.ex_imm !== 0 || bus.bubble_cnt !== 0 || bus2.bubble_cnt !== 0) begin
            failures++; $display("FAIL async_reset got v=%0b c=%b pc=%h cnt=%0d exp all 0",
                                 bus.ex_valid, bus.ex_ctrl, bus.ex_pc, bus.bubble_cnt);
        end
        model_reset();
        drive(1, 12, 0, 3, C_ALU, 2'b10, 3'b000, 7'd0, 0, 1);
        #2 reset = 1'b1;
        step();
        drive(1, 12, 0, 3, C_ALU, 2'b10, 3'b000, 7'd0, 0, 0);
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_flush_hazard();
        test_hold();
        test_saturate();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
